// File: rtl/mac_operand_sequencer_if.sv
// Operand-buffer write port, start/status and MAC operand/result signals
// shared between the sequencer and its environment.
interface mac_operand_sequencer_if #(
  parameter int N     = 5,
  parameter int WIDTH = 16
);
  localparam int RW = 2 * WIDTH + N - 1;

  logic             wr_en;
  logic             wr_sel;
  logic [7:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic             vld;
  logic             sof;
  logic [RW-1:0]    mac_c;
  logic [RW-1:0]    result;
  logic             result_valid;

  // vld, done and result_valid are one-way qualifying strobes with no ready
  // path: the MAC must take every pair in the cycle it is presented.
  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start, mac_c,
    input  busy, done, a_out, b_out, vld, sof, result, result_valid
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start, mac_c,
    output busy, done, a_out, b_out, vld, sof, result, result_valid
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Streams N buffered A/B element pairs to an external MAC, waits out its
// pipeline, then captures the accumulated result.
module mac_operand_sequencer #(
  parameter int N     = 5,
  parameter int WIDTH = 16,
  parameter int PIPE  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  mac_operand_sequencer_if.slave  bus,
  output logic [1:0]              state_dbg
);
  localparam int RW = 2 * WIDTH + N - 1;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = ($clog2(PIPE + 1) + 1 > 8) ? $clog2(PIPE + 1) + 1 : 8;
  localparam logic [7:0]    N_LAST = 8'(N - 1);
  localparam logic [DW-1:0] P_LAST = DW'(PIPE);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t           state_q, state_d;
  logic [7:0]       idx_q, idx_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic             capture, accept;
  logic             done_q, rv_q;
  logic [RW-1:0]    result_q;
  logic [WIDTH-1:0] buf_a [N];
  logic [WIDTH-1:0] buf_b [N];
  logic             wr_ok;

  // Buffers are deliberately left out of reset so a post-reset start replays them.
  assign wr_ok = bus.wr_en && (state_q == IDLE) && (bus.wr_addr <= N_LAST);

  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      if (bus.wr_sel) buf_b[bus.wr_addr[AW-1:0]] <= bus.wr_data;
      else            buf_a[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dcnt_d  = dcnt_q;
    capture = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = STREAM;
          idx_d   = 8'd0;
          accept  = 1'b1;
        end
      end
      STREAM: begin
        if (idx_q == N_LAST) begin
          state_d = DRAIN;
          dcnt_d  = '0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      DRAIN: begin
        if (dcnt_q == P_LAST) begin
          state_d = IDLE;
          capture = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 8'd0;
      dcnt_q   <= '0;
      done_q   <= 1'b0;
      rv_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dcnt_q  <= dcnt_d;
      done_q  <= capture;
      if (capture) begin
        result_q <= bus.mac_c;
        rv_q     <= 1'b1;
      end else if (accept) begin
        rv_q <= 1'b0;
      end
    end
  end

  assign bus.vld          = (state_q == STREAM);
  assign bus.sof          = (state_q == STREAM) && (idx_q == 8'd0);
  assign bus.a_out        = (state_q == STREAM) ? buf_a[idx_q[AW-1:0]] : '0;
  assign bus.b_out        = (state_q == STREAM) ? buf_b[idx_q[AW-1:0]] : '0;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = done_q;
  assign bus.result       = result_q;
  assign bus.result_valid = rv_q;
  assign state_dbg        = state_q;
endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Randomized bench for mac_operand_sequencer: a cycle-stamped reference model
// fills expectation queues, a negedge monitor compares every DUT cycle.
module tb_mac_operand_sequencer;
  localparam int N     = 5;
  localparam int WIDTH = 16;
  localparam int PIPE  = 2;
  localparam int RW    = 2 * WIDTH + N - 1;
  localparam int EW    = 32 + 2 * WIDTH + 1;
  localparam int LAT   = N + PIPE + 1;
  localparam int EV_CLR = 0, EV_CAP = 1, EV_RST = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] state_dbg;

  mac_operand_sequencer_if #(.N(N), .WIDTH(WIDTH)) bus();

  mac_operand_sequencer #(.N(N), .WIDTH(WIDTH), .PIPE(PIPE)) dut (
    .clk(clk), .rst(rst), .bus(bus), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  typedef struct {int cyc; int kind; logic [RW-1:0] val;} ev_t;
  logic [EW-1:0]    exp_q[$];
  int               done_q[$];
  ev_t              ev_q[$];
  logic [WIDTH-1:0] ref_a [N];
  logic [WIDTH-1:0] ref_b [N];
  int               idle_from = 0;
  int               acc_cycle = -1;
  int               cap_cycle = -1;
  logic [RW-1:0]    cap_val = '0;
  logic             m_rv = 1'b0;
  logic [RW-1:0]    m_res = '0;
  bit               mon_on = 1'b0;
  int               checks = 0;
  int               errors = 0;

  task automatic check(string name, logic [RW-1:0] got, logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic purge(int ne);
    logic [EW-1:0] tq[$];
    int            td[$];
    ev_t           te[$];
    logic [EW-1:0] w;
    foreach (exp_q[i]) begin
      w = exp_q[i];
      if (int'(w[EW-1 -: 32]) < ne) tq.push_back(w);
    end
    foreach (done_q[i]) if (done_q[i] < ne) td.push_back(done_q[i]);
    foreach (ev_q[i]) if (ev_q[i].cyc < ne) te.push_back(ev_q[i]);
    exp_q  = tq;
    done_q = td;
    ev_q   = te;
  endtask

  // driver: one call = inputs for the next rising edge (numbered cyc+1)
  task automatic tick(bit s, bit r, bit we, bit sel, logic [7:0] addr, logic [WIDTH-1:0] data);
    int            ne;
    logic [RW-1:0] dot;
    ne = cyc + 1;
    if (r) begin
      purge(ne);
      ev_q.push_back('{ne, EV_RST, '0});
      if (ne < idle_from) idle_from = ne;
      cap_cycle = -1;
    end else begin
      if (we && cyc >= idle_from && addr < N) begin
        if (sel) ref_b[addr] = data;
        else     ref_a[addr] = data;
      end
      if (s && cyc >= idle_from) begin
        dot = '0;
        for (int k = 0; k < N; k++) begin
          exp_q.push_back({32'(ne + k), ref_a[k], ref_b[k], 1'(k == 0)});
          dot += RW'(ref_a[k]) * RW'(ref_b[k]);
        end
        done_q.push_back(ne + LAT);
        ev_q.push_back('{ne, EV_CLR, '0});
        ev_q.push_back('{ne + LAT, EV_CAP, dot});
        acc_cycle = ne;
        idle_from = ne + LAT;
        cap_cycle = ne + LAT;
        cap_val   = dot;
      end
    end
    bus.mac_c   = (cap_cycle == ne) ? cap_val : RW'({$urandom(), $urandom()});
    bus.start   = s;
    rst         = r;
    bus.wr_en   = we;
    bus.wr_sel  = sel;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
  endtask

  // idle until the done cycle of the running operation (bounded)
  task automatic wait_done();
    for (int i = 0; i < LAT + 2 && cyc < idle_from; i++) idle(1);
    check("wait_done_bound", 1'(cyc >= idle_from), 1'b1);
  endtask

  // monitor
  logic [EW-1:0] mw;
  bit            exp_v, exp_d, exp_b;
  always @(negedge clk) begin
    while (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
      case (ev_q[0].kind)
        EV_CLR: m_rv = 1'b0;
        EV_CAP: begin m_rv = 1'b1; m_res = ev_q[0].val; end
        default: begin m_rv = 1'b0; m_res = '0; end
      endcase
      void'(ev_q.pop_front());
    end
    while (exp_q.size() > 0) begin
      mw = exp_q[0];
      if (int'(mw[EW-1 -: 32]) < cyc) void'(exp_q.pop_front());
      else break;
    end
    while (done_q.size() > 0 && done_q[0] < cyc) void'(done_q.pop_front());
    if (mon_on) begin
      exp_v = 1'b0;
      if (exp_q.size() > 0) begin
        mw = exp_q[0];
        exp_v = (int'(mw[EW-1 -: 32]) == cyc);
      end
      check("vld", bus.vld, exp_v);
      if (exp_v) begin
        void'(exp_q.pop_front());
        check("a_out", bus.a_out, mw[2*WIDTH:WIDTH+1]);
        check("b_out", bus.b_out, mw[WIDTH:1]);
        check("sof", bus.sof, mw[0]);
      end else begin
        check("idle_operands_zero", {bus.a_out, bus.b_out, bus.sof}, '0);
      end
      exp_d = (done_q.size() > 0 && done_q[0] == cyc);
      if (exp_d) void'(done_q.pop_front());
      check("done", bus.done, exp_d);
      exp_b = (cyc >= acc_cycle && cyc < idle_from);
      check("busy", bus.busy, exp_b);
      check("result_valid", bus.result_valid, m_rv);
      check("result", bus.result, m_res);
    end
  end

  // stimulus
  initial begin
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.mac_c = '0;
    for (int i = 0; i < N; i++) begin ref_a[i] = '0; ref_b[i] = '0; end

    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 16'h1111);
    mon_on = 1'b1;

    // A = 1..5, B = 6..10, then an out-of-range write
    for (int i = 0; i < N; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 8'(i), 16'(i + 1));
      tick(1'b0, 1'b0, 1'b1, 1'b1, 8'(i), 16'(i + 6));
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd5, 16'hdead);

    // operation with a stray start and a write while busy (result must be 130)
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0);
    for (int i = 0; i < LAT + 3; i++)
      tick(i == 2, 1'b0, i == 4, 1'b0, 8'd1, 16'hbeef);

    // re-run, then a start in the done cycle
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0);
    wait_done();
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0);
    wait_done();
    idle(3);

    // reset mid-stream, then replay
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0);
    idle(3);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 16'h5555);
    idle(3);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, '0);
    wait_done();
    idle(2);

    // random traffic
    for (int i = 0; i < 800; i++)
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 6)), WIDTH'($urandom()));

    idle(LAT + 3);
    check("exp_q_drained", RW'(exp_q.size()), '0);
    check("done_q_drained", RW'(done_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_operand_sequencer.md
MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 Parameter N, default 5: vector length, the number of element pairs streamed per operation (1..255).
REQ-002 Parameter WIDTH, default 16: operand element width in bits.
REQ-003 Parameter PIPE, default 2: downstream multiplier pipeline latency in cycles.
REQ-004 One clock; reset is synchronous and active-high. Ports clk and rst: clk is the single rising-edge clock; rst is the synchronous active-high reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 wr_en  input  1  operand buffer write strobe.
REQ-008 wr_sel  input  1  buffer select: 0 = A buffer, 1 = B buffer.
REQ-009 wr_addr  input  8  element index to write.
REQ-010 wr_data  input  WIDTH  element value to write.
REQ-011 start  input  1  request to stream one dot-product operation.
REQ-012 busy  output  1  high from the cycle after start is accepted until done.
REQ-013 done  output  1  one-cycle pulse when result is captured.
REQ-014 a_out, b_out  output  WIDTH each  operand pair driven to the MAC.
REQ-015 vld  output  1  a_out/b_out carry a valid element pair.
REQ-016 sof  output  1  marks the first element pair (index 0) of an operation.
REQ-017 mac_c  input  2*WIDTH+N-1  accumulated result returned by the MAC.
REQ-018 result  output  2*WIDTH+N-1  captured copy of mac_c.
REQ-019 result_valid  output  1  result holds the latest completed operation.

Function
REQ-020 The block SHALL hold two N-entry, WIDTH-bit buffers, A and B, written from wr_data at wr_addr when wr_en=1 in state IDLE.
- Writes with wr_addr >= N, and all writes while busy=1, SHALL be ignored.
REQ-021 The FSM states SHALL be IDLE, STREAM and DRAIN.
- IDLE -> STREAM on start=1.
- STREAM -> DRAIN after element N-1 is issued.
- DRAIN -> IDLE after PIPE+1 cycles.
REQ-022 When start is sampled high in IDLE (edge 0), STREAM SHALL drive element k of A and B on a_out/b_out during cycle k+1, for k = 0..N-1.
- vld=1 during each of these cycles.
- sof=1 only in the cycle carrying k=0.
REQ-023 When vld=0, a_out, b_out and sof SHALL be 0.
REQ-024 DRAIN SHALL last exactly PIPE+1 cycles, with vld=0 throughout.
- On the final DRAIN edge, result SHALL load mac_c, result_valid SHALL go to 1, done SHALL pulse for one cycle and busy SHALL fall; all of these are visible in cycle N+PIPE+2.
REQ-025 busy SHALL be 1 in cycles 1..N+PIPE+1 and 0 otherwise.
REQ-026 start asserted while busy=1 SHALL be ignored; there is no queuing.
REQ-027 start asserted in the same cycle that done is visible SHALL be accepted, because the state is IDLE.
REQ-028 result_valid SHALL clear on the edge that accepts a new start. result SHALL hold its value until the next capture.
REQ-029 Arithmetic is performed only in the MAC. The block SHALL capture mac_c unmodified, with no truncation.
REQ-030 Internal element counters SHALL be at least 8 bits wide and SHALL never index beyond N-1.

Reset
REQ-031 While rst=1 the block SHALL go to IDLE on the next edge and drive busy, done, vld, sof, a_out, b_out, result and result_valid to 0.
REQ-032 rst SHALL take priority over start and wr_en in the same cycle.
REQ-033 A reset during STREAM or DRAIN SHALL abort the operation with no done pulse.
REQ-034 Buffer contents SHALL be retained through reset.

Verification
REQ-035 N=5, PIPE=2. Write A=[1,2,3,4,5] and B=[6,7,8,9,10], then pulse start at edge 0.
- vld in cycles 1..5, sof only in cycle 1.
- a_out/b_out = (1,6), (2,7), ..., (5,10).
- done and result_valid in cycle 9.
REQ-036 Tie mac_c to 130 during DRAIN -> result=130 after done, and it holds while mac_c changes afterwards.
REQ-037 Pulse start in cycle 3 of an active operation -> no effect; the stream and the done timing are unchanged.
REQ-038 Write wr_addr=5 (with N=5) and write during busy -> buffers unchanged, which a re-run confirms.
REQ-039 Assert rst in cycle 4 of STREAM -> all outputs 0 next cycle and no done. The next start replays the same buffer contents.
REQ-040 Assert start in the cycle done is high -> a new stream begins the next cycle, result_valid clears and the old result is retained until the new capture.
